addsub_iter: RTL



---
 rtl/addsub_iter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/addsub_iter.sv
// Digit-serial two's-complement adder/subtractor.
// An accepted request is processed DIGIT bits per cycle, least significant
// slice first, and the result is held with its NZCV-style flags until the
// consumer takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// RUN   | adding one DIGIT-bit slice per cycle, cnt selects the slice
// DONE  | ans/cout/V/Z/N valid and frozen; out_valid high until taken
module addsub_iter #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIGIT-1:0] DIG_ONES = '1;

  // Reject geometries where the slices would not tile the word exactly.
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("addsub_iter: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ans_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             v_q;
  logic             z_q;
  logic             n_q;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   sum_dig;
  logic [WIDTH-1:0] slice_mask;
  logic [WIDTH-1:0] ans_next;
  logic             c_msb_in;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ans       = ans_q;
  assign cout      = cout_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign N         = n_q;

  // Slice adder: pick the current slice, add it with the running carry and
  // merge the sum back into the partial result.
  always_comb begin
    shamt      = 32'(cnt) * 32'(DIGIT);
    a_sh       = a_q >> shamt;
    b_sh       = b_q >> shamt;
    a_dig      = a_sh[DIGIT-1:0];
    b_dig      = b_sh[DIGIT-1:0];
    sum_dig    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    slice_mask = WIDTH'(DIG_ONES) << shamt;
    ans_next   = (ans_q & ~slice_mask) | (WIDTH'(sum_dig[DIGIT-1:0]) << shamt);
    // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ cin.
    c_msb_in   = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
    last       = (cnt == CW'(NDIG - 1));
  end

  // Sequencer and result registers; operands are captured only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ans_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            // Subtraction as A + ~B + 1: invert B here, inject the +1 as carry.
            b_q     <= B ^ {WIDTH{SUB}};
            carry_q <= SUB;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          ans_q   <= ans_next;
          carry_q <= sum_dig[DIGIT];
          cnt     <= cnt + CW'(1);
          if (last) begin
            cout_q <= sum_dig[DIGIT];
            v_q    <= c_msb_in ^ sum_dig[DIGIT];
            z_q    <= (ans_next == '0);
            n_q    <= ans_next[WIDTH-1];
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
